// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with MEM/WB operand bypass, stall and bubble insertion
module id_ex_operand_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall_E,
  input  logic        Flush_E,
  input  logic [31:0] Instr_D,
  input  logic [31:0] PC_D,
  input  logic [31:0] RD1_D,
  input  logic [31:0] RD2_D,
  input  logic [31:0] Ext_D,
  input  logic [3:0]  ALUOp_D,
  input  logic        ALUSrc_D,
  input  logic        RegWrite_D,
  input  logic [4:0]  WriteReg_D,
  input  logic        RegWrite_M,
  input  logic [4:0]  WriteReg_M,
  input  logic [31:0] ALUResult_M,
  input  logic        RegWrite_W,
  input  logic [4:0]  WriteReg_W,
  input  logic [31:0] Result_W,
  output logic [31:0] Instr_E,
  output logic [31:0] PC_E,
  output logic [3:0]  ALUOp_E,
  output logic [31:0] Data1_E,
  output logic [31:0] Data2_E,
  output logic [31:0] WriteData_E,
  output logic        RegWrite_E,
  output logic [4:0]  WriteReg_E,
  output logic        Valid_E
);
  logic [31:0] instr_q, pc_q, rd1_q, rd2_q, ext_q;
  logic [3:0]  aluop_q;
  logic        alusrc_q, regwrite_q, valid_q;
  logic [4:0]  writereg_q;
  logic [4:0]  rs, rt;
  logic        m_a, w_a, m_b, w_b;
  logic [31:0] fwd_a, fwd_b;
  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];
  assign m_a = RegWrite_M && WriteReg_M != 5'd0 && WriteReg_M == rs;
  assign w_a = RegWrite_W && WriteReg_W != 5'd0 && WriteReg_W == rs;
  assign m_b = RegWrite_M && WriteReg_M != 5'd0 && WriteReg_M == rt;
  assign w_b = RegWrite_W && WriteReg_W != 5'd0 && WriteReg_W == rt;
  assign fwd_a = m_a ? ALUResult_M : w_a ? Result_W : rd1_q;
  assign fwd_b = m_b ? ALUResult_M : w_b ? Result_W : rd2_q;
  // A stall recaptures the bypassed operands so they survive the producer retiring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || Flush_E) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      ext_q      <= '0;
      aluop_q    <= '0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      writereg_q <= '0;
      valid_q    <= 1'b0;
    end else if (Stall_E) begin
      rd1_q <= fwd_a;
      rd2_q <= fwd_b;
    end else begin
      instr_q    <= Instr_D;
      pc_q       <= PC_D;
      rd1_q      <= RD1_D;
      rd2_q      <= RD2_D;
      ext_q      <= Ext_D;
      aluop_q    <= ALUOp_D;
      alusrc_q   <= ALUSrc_D;
      regwrite_q <= RegWrite_D;
      writereg_q <= WriteReg_D;
      valid_q    <= 1'b1;
    end
  end
  assign Instr_E     = instr_q;
  assign PC_E        = pc_q;
  assign ALUOp_E     = aluop_q;
  assign Data1_E     = fwd_a;
  assign Data2_E     = alusrc_q ? ext_q : fwd_b;
  assign WriteData_E = fwd_b;
  assign RegWrite_E  = regwrite_q;
  assign WriteReg_E  = writereg_q;
  assign Valid_E     = valid_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed checks of load, bypass priority, immediate path, stall and flush
module tb_id_ex_operand_stage;
  logic        clk = 1'b0;
  logic        reset, Stall_E, Flush_E;
  logic [31:0] Instr_D, PC_D, RD1_D, RD2_D, Ext_D;
  logic [3:0]  ALUOp_D;
  logic        ALUSrc_D, RegWrite_D;
  logic [4:0]  WriteReg_D;
  logic        RegWrite_M;
  logic [4:0]  WriteReg_M;
  logic [31:0] ALUResult_M;
  logic        RegWrite_W;
  logic [4:0]  WriteReg_W;
  logic [31:0] Result_W;
  logic [31:0] Instr_E, PC_E, Data1_E, Data2_E, WriteData_E;
  logic [3:0]  ALUOp_E;
  logic        RegWrite_E, Valid_E;
  logic [4:0]  WriteReg_E;
  int total = 0;
  int bad = 0;
  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .Stall_E(Stall_E), .Flush_E(Flush_E),
    .Instr_D(Instr_D), .PC_D(PC_D), .RD1_D(RD1_D), .RD2_D(RD2_D), .Ext_D(Ext_D),
    .ALUOp_D(ALUOp_D), .ALUSrc_D(ALUSrc_D), .RegWrite_D(RegWrite_D), .WriteReg_D(WriteReg_D),
    .RegWrite_M(RegWrite_M), .WriteReg_M(WriteReg_M), .ALUResult_M(ALUResult_M),
    .RegWrite_W(RegWrite_W), .WriteReg_W(WriteReg_W), .Result_W(Result_W),
    .Instr_E(Instr_E), .PC_E(PC_E), .ALUOp_E(ALUOp_E), .Data1_E(Data1_E), .Data2_E(Data2_E),
    .WriteData_E(WriteData_E), .RegWrite_E(RegWrite_E), .WriteReg_E(WriteReg_E), .Valid_E(Valid_E)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; Stall_E = 1'b0; Flush_E = 1'b0;
    Instr_D = '0; PC_D = '0; RD1_D = '0; RD2_D = '0; Ext_D = '0;
    ALUOp_D = '0; ALUSrc_D = 1'b0; RegWrite_D = 1'b0; WriteReg_D = '0;
    RegWrite_M = 1'b0; WriteReg_M = '0; ALUResult_M = '0;
    RegWrite_W = 1'b0; WriteReg_W = '0; Result_W = '0;
    #1;
    chk("rst_instr", Instr_E, 32'h0);
    chk("rst_valid", {31'd0, Valid_E}, 32'd0);
    chk("rst_data1", Data1_E, 32'd0);
    chk("rst_data2", Data2_E, 32'd0);
    tick;
    reset = 1'b0;
    // addi $8,$9,5 then asynchronous reset between edges
    Instr_D = 32'h2128_0005; ALUOp_D = 4'h2; RegWrite_D = 1'b1; WriteReg_D = 5'd8;
    ALUSrc_D = 1'b1; Ext_D = 32'd5; PC_D = 32'h40;
    tick;
    chk("addi_instr", Instr_E, 32'h2128_0005);
    chk("addi_valid", {31'd0, Valid_E}, 32'd1);
    chk("addi_aluop", {28'd0, ALUOp_E}, 32'h2);
    #2 reset = 1'b1;
    #1;
    chk("amid_instr", Instr_E, 32'h0);
    chk("amid_regwr", {31'd0, RegWrite_E}, 32'd0);
    chk("amid_valid", {31'd0, Valid_E}, 32'd0);
    chk("amid_aluop", {28'd0, ALUOp_E}, 32'h0);
    chk("amid_pc", PC_E, 32'h0);
    reset = 1'b0;
    // add $8,$9,$10
    Instr_D = 32'h012A_4020; RD1_D = 32'd5; RD2_D = 32'd7; ALUSrc_D = 1'b0; Ext_D = 32'h4020;
    ALUOp_D = 4'h0; RegWrite_D = 1'b1; WriteReg_D = 5'd8; PC_D = 32'h100;
    tick;
    chk("add_data1", Data1_E, 32'd5);
    chk("add_data2", Data2_E, 32'd7);
    chk("add_wdata", WriteData_E, 32'd7);
    chk("add_wreg", {27'd0, WriteReg_E}, 32'd8);
    chk("add_valid", {31'd0, Valid_E}, 32'd1);
    chk("add_pc", PC_E, 32'h100);
    RegWrite_M = 1'b1; WriteReg_M = 5'd9; ALUResult_M = 32'h11;
    RegWrite_W = 1'b1; WriteReg_W = 5'd9; Result_W = 32'h22;
    #1 chk("fwd_m_over_w", Data1_E, 32'h11);
    RegWrite_M = 1'b0;
    #1 chk("fwd_w_only", Data1_E, 32'h22);
    RegWrite_M = 1'b1; WriteReg_M = 5'd0;
    #1 chk("fwd_m_zero", Data1_E, 32'h22);
    chk("fwd_rt_none", Data2_E, 32'd7);
    WriteReg_M = 5'd10; ALUResult_M = 32'h44;
    #1 chk("fwd_rt_m_d2", Data2_E, 32'h44);
    chk("fwd_rt_m_wd", WriteData_E, 32'h44);
    chk("fwd_rs_w_kept", Data1_E, 32'h22);
    RegWrite_M = 1'b0; RegWrite_W = 1'b0;
    // sw $10,-4($9)
    Instr_D = 32'hAD2A_FFFC; Ext_D = 32'hFFFF_FFFC; ALUSrc_D = 1'b1; RegWrite_D = 1'b0; RD2_D = 32'd7;
    tick;
    RegWrite_W = 1'b1; WriteReg_W = 5'd10; Result_W = 32'h99;
    #1 chk("imm_data2", Data2_E, 32'hFFFF_FFFC);
    chk("imm_wdata", WriteData_E, 32'h99);
    chk("imm_regwr", {31'd0, RegWrite_E}, 32'd0);
    // stall retention of a W-bypassed rs
    Instr_D = 32'h012A_4020; RD1_D = 32'd5; ALUSrc_D = 1'b0; RegWrite_D = 1'b1; PC_D = 32'h200;
    WriteReg_W = 5'd9; Result_W = 32'h33;
    tick;
    chk("stl_pre_d1", Data1_E, 32'h33);
    Stall_E = 1'b1; Instr_D = 32'hFFFF_FFFF; RD1_D = 32'hBAD; PC_D = 32'h300;
    tick;
    WriteReg_W = 5'd3; Result_W = 32'h77;
    #1 chk("stl_data1", Data1_E, 32'h33);
    chk("stl_instr", Instr_E, 32'h012A_4020);
    chk("stl_pc", PC_E, 32'h200);
    chk("stl_valid", {31'd0, Valid_E}, 32'd1);
    // flush wins over stall; W write to $0 must not forward
    Flush_E = 1'b1;
    tick;
    Stall_E = 1'b0; Flush_E = 1'b0;
    WriteReg_W = 5'd0; Result_W = 32'h55;
    #1 chk("fl_valid", {31'd0, Valid_E}, 32'd0);
    chk("fl_regwr", {31'd0, RegWrite_E}, 32'd0);
    chk("fl_instr", Instr_E, 32'h0);
    chk("fl_w_zero_d1", Data1_E, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register plus EX-stage operand forwarding. It sits directly upstream of the EX-stage ALU and drives the ALU's Data1, Data2, Instr and ALUOp inputs every cycle. It latches decode-stage values, resolves RAW hazards by bypassing from the MEM and WB stages, and supports pipeline stall and bubble insertion.

Parameters:
NOP_INSTR, 32'h0000_0000, instruction word loaded on reset/flush (sll $0,$0,0)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high
Stall_E  in  1  hold E-stage contents this cycle
Flush_E  in  1  load bubble this cycle
Instr_D  in  32  decoded instruction word
PC_D  in  32  instruction PC
RD1_D  in  32  register file read data, rs
RD2_D  in  32  register file read data, rt
Ext_D  in  32  extended immediate
ALUOp_D  in  4  ALU operation code
ALUSrc_D  in  1  1: Data2 = immediate
RegWrite_D  in  1  instruction writes a GPR
WriteReg_D  in  5  destination GPR
RegWrite_M  in  1  MEM-stage write enable
WriteReg_M  in  5  MEM-stage destination
ALUResult_M  in  32  MEM-stage ALU result
RegWrite_W  in  1  WB-stage write enable
WriteReg_W  in  5  WB-stage destination
Result_W  in  32  WB-stage write-back data
Instr_E  out  32  to ALU Instr (shamt source)
PC_E  out  32  E-stage PC
ALUOp_E  out  4  to ALU ALUOp
Data1_E  out  32  to ALU Data1 (forwarded rs)
Data2_E  out  32  to ALU Data2
WriteData_E  out  32  forwarded rt (store data)
RegWrite_E  out  1  E-stage write enable
WriteReg_E  out  5  E-stage destination
Valid_E  out  1  0 while E holds a bubble

Behaviour:
- Registered fields: Instr, PC, RD1, RD2, Ext, ALUOp, ALUSrc, RegWrite, WriteReg, Valid.
- Reset (async, immediate): Instr=NOP_INSTR; PC, RD1, RD2, Ext=0; ALUOp=4'b0000; ALUSrc, RegWrite, Valid=0; WriteReg=0. Outputs follow at once: Data1_E=Data2_E=WriteData_E=0 unless a forward from M/W matches (see below). Reset mid-stall drops the held instruction.
- Edge priority: reset > Flush_E > Stall_E > load.
  - Flush: load the reset values; Flush_E wins when Stall_E is also high.
  - Stall: all fields hold, except RD1/RD2, which reload from the current forwarded operands FwdA/FwdB. This keeps bypassed values valid after the producer retires.
  - Load: capture all _D inputs; Valid=1.
- Latency: one cycle from _D inputs to E-stage outputs. Forwarding is combinational on E-register contents and the M/W ports, with no added cycle.
- Forwarding:
  - rs = Instr_E[25:21], rt = Instr_E[20:16].
  - FwdA = ALUResult_M if RegWrite_M && WriteReg_M!=0 && WriteReg_M==rs.
  - Otherwise FwdA = Result_W if RegWrite_W && WriteReg_W!=0 && WriteReg_W==rs.
  - Otherwise FwdA = RD1 register.
  - FwdB is identical, using rt and RD2.
  - M has priority over W. Register $0 is never forwarded.
- Outputs: Data1_E=FwdA; Data2_E = ALUSrc ? Ext : FwdB; WriteData_E=FwdB. All other outputs are direct register values.
- Widths: all data paths are 32-bit with no arithmetic here. The 5-bit compares are exact equality.

Test Plan:
- Reset mid-operation: load an addi, assert reset between edges -> Instr_E=0, RegWrite_E=0, Valid_E=0, ALUOp_E=0 immediately, before the next clk.
- Plain load: Instr_D=0x012A4020 (add $8,$9,$10), RD1_D=5, RD2_D=7, ALUSrc_D=0, no M/W writes -> next cycle Data1_E=5, Data2_E=7, WriteReg_E=8, Valid_E=1.
- Forward priority: E rs=$9; RegWrite_M=1, WriteReg_M=9, ALUResult_M=0x11; RegWrite_W=1, WriteReg_W=9, Result_W=0x22 -> Data1_E=0x11. Drop the M write -> Data1_E=0x22. WriteReg_M=0 with RegWrite_M=1 -> no forward from M.
- Immediate path: ALUSrc_D=1, Ext_D=0xFFFFFFFC, rt forwarded from W with 0x99 -> Data2_E=0xFFFFFFFC, WriteData_E=0x99.
- Stall retention: E holds rs=$9, W forwards 0x33, assert Stall_E for 1 cycle, then W changes to unrelated $3 -> Data1_E stays 0x33 and Instr_E is unchanged throughout the stall.
- Flush vs stall: Stall_E=1 and Flush_E=1 together -> next cycle is a bubble (Valid_E=0, RegWrite_E=0, Instr_E=0).
